// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and entry type for the fetch queue
package fetch_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_INC    = 4;

  // Queue entry at the widest supported PC width; narrower cores use the low bits.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch storage with pointers, occupancy and flush
module fetch_fifo #(
  parameter int               DEPTH    = 4,
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int              PW       = $clog2(DEPTH),
  localparam int              CW       = PW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  // Entry storage; reset restores every slot to the idle value so the head reads as a NOP.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VAL;
    end else if (push && !flush) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; flush empties the queue without touching storage.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign rdata = mem[rptr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC-owning fetch stage with prefetch queue; FETCH_STEP_EN adds single-step fetch
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clock,
  input  logic                   reset,
`ifdef FETCH_STEP_EN
  input  logic                   step,
`endif
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]     imem_data,
  input  logic                   imem_ready,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] pc;
  logic              pop;
  logic              can_push;
  logic              push;
  logic              fetch_ok;
  logic [EW-1:0]     head;

`ifdef FETCH_STEP_EN
  logic step_q;
  logic step_pending;

  // A rising edge of step arms exactly one fetch; the push consumes it, redirect/reset cancel it.
  always_ff @(posedge clock) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
    if (reset || redirect)   step_pending <= 1'b0;
    else if (step && !step_q) step_pending <= 1'b1;
    else if (push)           step_pending <= 1'b0;
  end

  assign fetch_ok = step_pending;
`else
  assign fetch_ok = 1'b1;
`endif

  assign pop      = out_valid & out_ready;
  assign can_push = (count < CW'(DEPTH)) | pop;
  assign push     = can_push & imem_ready & ~redirect & fetch_ok;

  // PC register: redirect wins, otherwise advance only when an instruction is captured.
  always_ff @(posedge clock) begin
    if (reset)         pc <= RESET_PC;
    else if (redirect) pc <= redirect_pc & ~ADDR_W'(3);
    else if (push)     pc <= pc + ADDR_W'(PC_INC);
  end

  fetch_fifo #(
    .DEPTH    (DEPTH),
    .WIDTH    (EW),
    .INIT_VAL ({ADDR_W'(0), NOP_INSTR})
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .pop   (pop & ~redirect),
    .wdata ({pc, imem_data}),
    .rdata (head),
    .count (count)
  );

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_pc    = head[EW-1:INSTR_W];
  assign out_instr = head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a queue-based reference
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RP    = 32'h100;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clock;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  logic [7:0]  w_addr;
  logic [31:0] w_data;
  logic        w_valid;
  logic [7:0]  w_pc;
  logic [31:0] w_instr;
  logic [2:0]  w_count;

`ifdef FETCH_STEP_EN
  logic step;
  logic w_step;
`endif

  int   checks;
  int   failures;
  ent_t mq[$];
  logic [31:0] m_pc;
  bit   m_pend;
  bit   m_stq;
  bit   w_collect;
  logic [7:0]  wq[$];
  logic [31:0] wi[$];

  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign imem_data = f(imem_addr);
  assign w_data    = f({24'h0, w_addr});

  fetch_queue #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(RP)) dut (
    .clock       (clock),
    .reset       (reset),
`ifdef FETCH_STEP_EN
    .step        (step),
`endif
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .imem_ready  (imem_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .count       (count)
  );

  fetch_queue #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'hF8)) dut_wrap (
    .clock       (clock),
    .reset       (reset),
`ifdef FETCH_STEP_EN
    .step        (w_step),
`endif
    .imem_addr   (w_addr),
    .imem_data   (w_data),
    .imem_ready  (1'b1),
    .redirect    (1'b0),
    .redirect_pc (8'h00),
    .out_valid   (w_valid),
    .out_ready   (1'b1),
    .out_pc      (w_pc),
    .out_instr   (w_instr),
    .count       (w_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef FETCH_STEP_EN
  initial begin
    w_step = 1'b0;
    forever @(negedge clock) w_step = ~w_step;
  end
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the model, advance both, then compare at the falling edge.
  task automatic cyc();
    bit   pop_m;
    bit   push_m;
    bit   was_rst;
    ent_t e;
    ent_t d;
    pop_m  = (mq.size() != 0) && out_ready;
    push_m = ((mq.size() < DEPTH) || pop_m) && imem_ready && !redirect;
`ifdef FETCH_STEP_EN
    push_m = push_m && m_pend;
`endif
    e.pc    = m_pc;
    e.instr = f(m_pc);
    was_rst = reset;
    @(posedge clock);
    if (reset) begin
      mq.delete();
      m_pc = RP;
    end else if (redirect) begin
      mq.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (pop_m) d = mq.pop_front();
      if (push_m) begin
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
`ifdef FETCH_STEP_EN
    if (reset || redirect)   m_pend = 1'b0;
    else if (step && !m_stq) m_pend = 1'b1;
    else if (push_m)         m_pend = 1'b0;
    m_stq = reset ? 1'b0 : step;
`endif
    @(negedge clock);
    chk("imem_addr", imem_addr, m_pc);
    chk("count", count, mq.size());
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_instr", out_instr, mq[0].instr);
    end
    if (was_rst) begin
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_instr", out_instr, 0);
    end
    if (w_collect && w_valid && wq.size() < 4) begin
      wq.push_back(w_pc);
      wi.push_back(w_instr);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] wexp [4];
    checks = 0;
    failures = 0;
    m_pc = RP;
    m_pend = 1'b0;
    m_stq = 1'b0;
    w_collect = 1'b0;
    reset = 1'b1;
    imem_ready = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
`ifdef FETCH_STEP_EN
    step = 1'b0;
`endif
    @(negedge clock);

    // Reset values
    do_reset();
    chk("rst_imem_addr", imem_addr, RP);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("wrap_rst_addr", w_addr, 8'hF8);

    // Free run from reset; the 8-bit instance is observed for PC wrap
    w_collect = 1'b1;
    for (int i = 0; i < 14; i++) begin
`ifdef FETCH_STEP_EN
      step = i[0];
`endif
      cyc();
`ifndef FETCH_STEP_EN
      if (i < 3) begin
        chk("free_valid", out_valid, 1);
        chk("free_out_pc", out_pc, RP + 32'(4 * i));
        chk("free_imem_addr", imem_addr, RP + 32'(4 * (i + 1)));
      end
`endif
    end
    w_collect = 1'b0;
    wexp[0] = 8'hF8; wexp[1] = 8'hFC; wexp[2] = 8'h00; wexp[3] = 8'h04;
    chk("wrap_entries", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      chk("wrap_pc", wq[i], wexp[i]);
      chk("wrap_instr", wi[i], f({24'h0, wexp[i]}));
    end

    // Full queue with decode stalled, then streaming at full occupancy
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
`ifndef FETCH_STEP_EN
    chk("full_count", count, 4);
    chk("full_imem_addr", imem_addr, RP + 32'd16);
    chk("full_head", out_pc, RP);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
`ifndef FETCH_STEP_EN
      chk("stream_count", count, 4);
`endif
    end

    // Redirect with entries queued, then back-to-back redirects
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    redirect = 1'b1;
    redirect_pc = 32'h203;
    cyc();
    chk("redir_count", count, 0);
    chk("redir_valid", out_valid, 0);
    chk("redir_imem_addr", imem_addr, 32'h200);
    redirect = 1'b0;
    out_ready = 1'b1;
    cyc();
`ifndef FETCH_STEP_EN
    chk("redir_first_pc", out_pc, 32'h200);
`endif
    redirect = 1'b1;
    redirect_pc = 32'h300;
    cyc();
    redirect_pc = 32'h407;
    cyc();
    redirect = 1'b0;
    chk("redir_last_wins", imem_addr, 32'h404);

    // Wait states: ready pattern 1,0,0,1 yields two contiguous entries
    do_reset();
    out_ready = 1'b0;
    imem_ready = 1'b1; cyc();
    imem_ready = 1'b0; cyc();
    cyc();
    imem_ready = 1'b1; cyc();
    imem_ready = 1'b0;
`ifndef FETCH_STEP_EN
    chk("wait_count", count, 2);
    chk("wait_head", out_pc, RP);
`endif
    out_ready = 1'b1;
    cyc();
`ifndef FETCH_STEP_EN
    chk("wait_second", out_pc, RP + 32'd4);
`endif

`ifdef FETCH_STEP_EN
    // Step held high for 5 cycles then two isolated pulses: three fetches
    do_reset();
    out_ready = 1'b0;
    imem_ready = 1'b1;
    step = 1'b0; cyc();
    step = 1'b1; for (int i = 0; i < 5; i++) cyc();
    step = 1'b0; cyc(); cyc();
    step = 1'b1; cyc();
    step = 1'b0; cyc(); cyc();
    step = 1'b1; cyc();
    step = 1'b0; cyc(); cyc(); cyc();
    chk("step_count", count, 3);
`endif

    // Randomised traffic against the reference queue
    do_reset();
    for (int i = 0; i < 400; i++) begin
      imem_ready  = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      reset       = ($urandom_range(0, 63) == 0);
`ifdef FETCH_STEP_EN
      step        = $urandom_range(0, 1) != 0;
`endif
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch stage that generalises the single-register fetch path of the pipelined core.
- Owns the PC and drives the combinational instruction memory. Buffers fetched {pc, instr} pairs in a DEPTH-entry prefetch queue and hands them to decode over a valid/ready handshake.
- Supports redirect-with-flush for branches and jumps, and memory wait states.
- Sits between instruction_memory and the IF/ID pipeline buffer.

Parameters:
- ADDR_W, 32, PC / instruction-address width.
- DEPTH, 4, queue entries; power of two, >=2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  core clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- imem_addr  out  ADDR_W  fetch address; equals the internal PC register.
- imem_data  in  32  instruction at imem_addr, valid in the same cycle.
- imem_ready  in  1  1 = imem_data valid this cycle; 0 = wait state.
- redirect  in  1  branch/jump taken; flush the queue.
- redirect_pc  in  ADDR_W  new fetch PC; bits [1:0] ignored (forced to 0).
- out_valid  out  1  head entry present.
- out_ready  in  1  decode accepts the head entry.
- out_pc  out  ADDR_W  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- count  out  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (synchronous):
  - PC <= RESET_PC, pointers and count <= 0.
  - All storage entries cleared to {0, NOP=32'h0}.
  - out_valid=0, out_pc=0, out_instr=0, imem_addr=RESET_PC.
  - A reset asserted mid-operation discards all queued entries, any redirect and any pending push.
- Definitions:
  - pop = out_valid & out_ready.
  - can_push = (count < DEPTH) | pop. Pushing into a full queue is permitted in the same cycle as a pop.
  - push = can_push & imem_ready & ~redirect.
- Push:
  - Writes {PC, imem_data} at the write pointer.
  - PC <= PC + 4, modulo 2^ADDR_W (so 2^ADDR_W-4 wraps to 0).
- Pop: advances the read pointer.
- Count update: count <= count + push - pop. Simultaneous push and pop leaves count unchanged.
- Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Outputs:
  - out_valid = (count != 0).
  - out_pc and out_instr are driven from the head storage entry.
  - Minimum latency from imem sample to out_valid is 1 cycle.
- Output stability: while out_valid=1 and out_ready=0, out_pc and out_instr are held stable.
- Redirect has highest priority:
  - In the cycle redirect=1: no push, pop ignored, pointers <= 0, count <= 0, PC <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - The next cycle shows out_valid=0 and imem_addr = the new PC.
  - Back-to-back redirects: the last one wins.
- Wait states: imem_ready=0 means no push and the PC holds. Pops continue.
- Full: when count=DEPTH and out_ready=0, the PC holds and imem_addr is stable.
- Empty: out_valid=0; out_ready is a don't-care.

Optional Feature:
- Macro FETCH_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - A registered rising-edge detector sets step_pending.
  - A push additionally requires step_pending=1 and clears it, so exactly one instruction is fetched per step pulse.
  - Redirect and reset clear step_pending.
  - Pops are unaffected.
- When undefined: the step port is absent and fetch is free-running as described in Behaviour.

Decomposition:
- Package fetch_pkg holds INSTR_W=32, NOP_INSTR=32'h0000_0000, PC_INC=4, and a typedef for the {pc, instr} entry struct.
- One sub-module, fetch_fifo: storage array, pointers, count, flush input. Parametrised by DEPTH and entry width.
- PC logic, redirect priority and the step gating stay in the top.

Test Plan:
- Reset then free-run, imem_ready=1, out_ready=1, RESET_PC=0x100: imem_addr steps 0x100, 0x104, ...; out_valid rises 1 cycle after reset deassert; out_pc sequence 0x100, 0x104, 0x108 with matching instrs.
- Full queue, out_ready=0, DEPTH=4: count reaches 4 after 4 cycles; imem_addr frozen at RESET_PC+16; head remains 0x100. Raise out_ready: one pop and one push per cycle, count stays 4.
- Redirect with 3 entries queued, redirect_pc=0x203: next cycle count=0, out_valid=0, imem_addr=0x200; first delivered out_pc=0x200.
- Wait states, imem_ready pattern 1,0,0,1: exactly 2 pushes, PCs contiguous (0x100, 0x104), no duplicate or skipped entry.
- PC wrap, ADDR_W=8, RESET_PC=0xF8: delivered out_pc sequence is 0xF8, 0xFC, 0x00, 0x04.
- With FETCH_STEP_EN, step held high for 5 cycles, then 2 separate pulses: exactly 3 entries pushed (one per rising edge); count=3 with out_ready=0.
